// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Optional macro DIVIDER_DIV_BY_ZERO_EXC_EN adds a fast divide-by-zero exit and a div_by_zero flag.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
`else
   output logic [WIDTH-1:0] remainder
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      DZERO = 2'd3
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qbit;
   logic [WIDTH-1:0] next_rem;
   logic [WIDTH-1:0] next_dividend;

   // The partial remainder is always below the divisor, so the top bit of the
   // WIDTH+1 bit difference is a reliable borrow flag.
   always_comb begin
      shifted       = {part_rem, dividend[WIDTH-1]};
      diff          = shifted - {1'b0, divisor};
      qbit          = ~diff[WIDTH];
      next_rem      = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      next_dividend = {dividend[WIDTH-2:0], qbit};
   end

   // Quotient bits shift into the low end of the dividend register as its
   // high bits move into the partial remainder.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         part_rem    <= '0;
         dividend    <= '0;
         divisor     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
               div_by_zero <= 1'b0;
`endif
               if (start) begin
                  dividend <= in1;
                  divisor  <= in2;
                  part_rem <= '0;
                  count    <= '0;
                  busy     <= 1'b1;
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
                  state    <= (in2 == '0) ? DZERO : BUSY;
`else
                  state    <= BUSY;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               part_rem <= next_rem;
               dividend <= next_dividend;
               count    <= count + 1'b1;
               if (count == LAST) begin
                  quotient  <= next_dividend;
                  remainder <= next_rem;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
            DZERO: begin
               quotient    <= '1;
               remainder   <= dividend;
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= 1'b1;
               state       <= DONE;
            end
`endif
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed scenarios plus random operands checked
// against plain-arithmetic division.
module tb_divider;

   localparam int W = 32;
   localparam int TIMEOUT = 100;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
   logic         div_by_zero;
`endif

   int checks = 0;
   int errors = 0;

   divider #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in1        (in1),
      .in2        (in2),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
`else
      .remainder  (remainder)
`endif
   );

   always #5 clock = ~clock;

   // Reference division straight from the arithmetic definition.
   function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? {W{1'b1}} : a / b;
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) ? a : a % b;
   endfunction

   function automatic int ref_lat(input logic [W-1:0] b);
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
      return (b == 0) ? 1 : W;
`else
      return W;
`endif
   endfunction

   // Called 1 time unit after a rising edge. Counts edges after the accepting
   // edge until done, and counts cycles where busy disagrees (1 before done, 0 at done).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bad_busy);
      start = 1'b1;
      in1   = a;
      in2   = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      in1   = $urandom;
      in2   = $urandom;
      lat      = 0;
      bad_busy = 0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         if (busy !== 1'b1) bad_busy++;
         @(posedge clock);
         #1;
         lat++;
      end
      if (busy !== 1'b0) bad_busy++;
   endtask

   task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int lat, input int bad_busy);
      checks++;
      if (quotient !== ref_q(a, b)) begin
         errors++;
         $display("[TB] FAIL %s quotient: got %0h expected %0h", name, quotient, ref_q(a, b));
      end
      checks++;
      if (remainder !== ref_r(a, b)) begin
         errors++;
         $display("[TB] FAIL %s remainder: got %0h expected %0h", name, remainder, ref_r(a, b));
      end
      checks++;
      if (lat != ref_lat(b)) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, ref_lat(b));
      end
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("[TB] FAIL %s busy: got %0d wrong cycles expected 0", name, bad_busy);
      end
`ifdef DIVIDER_DIV_BY_ZERO_EXC_EN
      checks++;
      if (div_by_zero !== (b == 0)) begin
         errors++;
         $display("[TB] FAIL %s div_by_zero: got %0b expected %0b", name, div_by_zero, (b == 0));
      end
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      in1   = '0;
      in2   = '0;
      #1;
      checks++;
      if ({busy, done, quotient, remainder} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got busy=%0b done=%0b q=%0h r=%0h expected all 0",
                  busy, done, quotient, remainder);
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got busy=%0b done=%0b expected 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int lat, bb;
      run_op(32'd100, 32'd7, lat, bb);
      check_result("basic_100_7", 32'd100, 32'd7, lat, bb);
      @(posedge clock);
      #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_one_cycle: got %0b expected 0", done);
      end
   endtask

   task automatic test_extremes();
      int lat, bb;
      run_op(32'hFFFF_FFFF, 32'd1, lat, bb);
      check_result("max_div_1", 32'hFFFF_FFFF, 32'd1, lat, bb);
      @(posedge clock);
      #1;
      run_op(32'hFFFF_FFFF, 32'h8000_0000, lat, bb);
      check_result("max_div_msb", 32'hFFFF_FFFF, 32'h8000_0000, lat, bb);
      @(posedge clock);
      #1;
   endtask

   task automatic test_back_to_back();
      int lat, bb;
      run_op(32'd5, 32'd9, lat, bb);
      check_result("small_5_9", 32'd5, 32'd9, lat, bb);
      // Still in the DONE cycle: start again immediately, checking the old result holds.
      start = 1'b1;
      in1   = 32'd81;
      in2   = 32'd9;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat   = 0;
      bb    = 0;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         if (busy !== 1'b1) bb++;
         if (lat == 5) begin
            checks++;
            if (quotient !== 32'd0 || remainder !== 32'd5) begin
               errors++;
               $display("[TB] FAIL result_hold: got q=%0h r=%0h expected q=0 r=5", quotient, remainder);
            end
         end
         @(posedge clock);
         #1;
         lat++;
      end
      check_result("b2b_81_9", 32'd81, 32'd9, lat, bb);
      @(posedge clock);
      #1;
   endtask

   task automatic test_ignore_start();
      int lat;
      start = 1'b1;
      in1   = 32'd50;
      in2   = 32'd5;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      start = 1'b1;
      in1   = 32'd1;
      in2   = 32'd1;
      @(posedge clock);
      #1;
      start = 1'b0;
      in1   = 32'd77;
      in2   = 32'd3;
      lat   = 10;
      while (done !== 1'b1 && lat < TIMEOUT) begin
         @(posedge clock);
         #1;
         lat++;
      end
      check_result("ignore_start_50_5", 32'd50, 32'd5, lat, 0);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat, bb;
      start = 1'b1;
      in1   = 32'd1000;
      in2   = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, quotient, remainder} !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got busy=%0b done=%0b q=%0h r=%0h expected all 0",
                  busy, done, quotient, remainder);
      end
      @(negedge clock);
      reset = 1'b0;
      lat = 0;
      repeat (W + 2) begin
         @(posedge clock);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) lat++;
      end
      checks++;
      if (lat != 0) begin
         errors++;
         $display("[TB] FAIL abandoned_op: got %0d active cycles expected 0", lat);
      end
      run_op(32'd1000, 32'd3, lat, bb);
      check_result("after_reset_1000_3", 32'd1000, 32'd3, lat, bb);
      @(posedge clock);
      #1;
   endtask

   task automatic test_div_zero();
      int lat, bb;
      run_op(32'd1234, 32'd0, lat, bb);
      check_result("div_zero_1234", 32'd1234, 32'd0, lat, bb);
      @(posedge clock);
      #1;
   endtask

   task automatic test_random();
      int lat, bb;
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom >> $urandom_range(0, 20);
         b = $urandom >> $urandom_range(0, 31);
         if (i % 8 == 3) b = '0;
         run_op(a, b, lat, bb);
         check_result("random", a, b, lat, bb);
         if (i % 2 == 0) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_div_zero();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
